// File: rtl/vector_multiply_arbiter.sv
// Round-robin arbiter sharing one fixed-latency vector multiplier between two requesters.
// Results return in grant order through a credit-gated FIFO, tagged with the requester id.
module vector_multiply_arbiter #(
  parameter int MUL_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int VLEN        = 128,
  parameter int EXEC_W      = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][EXEC_W-1:0] req_execution_vector,
  input  logic [1:0][VLEN-1:0]   req_vs2,
  input  logic [1:0][VLEN-1:0]   req_vs1,
  output logic [EXEC_W-1:0]      mul_execution_vector,
  output logic [VLEN-1:0]        mul_vs2,
  output logic [VLEN-1:0]        mul_vs1,
  input  logic [VLEN-1:0]        mul_vd,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VLEN-1:0]        res_vd,
  output logic                   res_id,
  output logic                   busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + MUL_LATENCY + 1);

  logic                   prio;
  logic [1:0]             win;
  logic                   credit;
  logic                   grant;
  logic                   grant_id;
  logic [MUL_LATENCY-1:0] track_valid;
  logic [MUL_LATENCY-1:0] track_id;
  logic [OCC_W-1:0]       inflight_cnt;
  logic [OCC_W-1:0]       occupancy;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic [VLEN-1:0]        fifo_vd [FIFO_DEPTH];
  logic                   fifo_id [FIFO_DEPTH];
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits count every granted op not yet popped; a pop frees its credit one cycle later.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + OCC_W'(track_valid[i]);
    end
    occupancy = inflight_cnt + OCC_W'(fifo_count);
  end

  assign credit = (occupancy < OCC_W'(FIFO_DEPTH));

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and req_ready never looks at res_ready.
  always_comb begin
    win = 2'b00;
    case (req_valid)
      2'b11:   win[prio] = 1'b1;
      default: win = req_valid;
    endcase
    req_ready = (credit && !reset) ? win : 2'b00;
  end

  assign grant    = |req_ready;
  assign grant_id = req_ready[1];

  always_comb begin
    mul_execution_vector = '0;
    mul_vs2              = '0;
    mul_vs1              = '0;
    if (grant) begin
      mul_execution_vector = req_execution_vector[grant_id];
      mul_vs2              = req_vs2[grant_id];
      mul_vs1              = req_vs1[grant_id];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio        <= 1'b0;
      track_valid <= '0;
      track_id    <= '0;
    end else begin
      if (grant) prio <= ~grant_id;
      track_valid[0] <= grant;
      track_id[0]    <= grant_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        track_valid[i] <= track_valid[i-1];
        track_id[i]    <= track_id[i-1];
      end
    end
  end

  assign push = track_valid[MUL_LATENCY-1];
  assign pop  = res_valid && res_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_vd[wr_ptr] <= mul_vd;
      fifo_id[wr_ptr] <= track_id[MUL_LATENCY-1];
    end
  end

  assign res_valid = (fifo_count != '0);
  assign res_vd    = fifo_vd[rd_ptr];
  assign res_id    = fifo_id[rd_ptr];
  assign busy      = (occupancy != '0);

  // Credit gating keeps a full FIFO from ever seeing another result.
  assert property (@(posedge clock) disable iff (reset)
    !(push && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_vector_multiply_arbiter.sv
// Bench for vector_multiply_arbiter: a queue-based model of grants, credits and result order,
// checked every cycle, plus hand-computed directed expectations.
module tb_vector_multiply_arbiter;

  localparam int VLEN   = 32;
  localparam int EXEC_W = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;
  localparam int SEW    = 8;
  localparam int NEL    = VLEN / SEW;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][EXEC_W-1:0] req_execution_vector;
  logic [1:0][VLEN-1:0]   req_vs2;
  logic [1:0][VLEN-1:0]   req_vs1;
  logic [EXEC_W-1:0]      mul_execution_vector;
  logic [VLEN-1:0]        mul_vs2;
  logic [VLEN-1:0]        mul_vs1;
  logic [VLEN-1:0]        mul_vd;
  logic                   res_valid;
  logic                   res_ready;
  logic [VLEN-1:0]        res_vd;
  logic                   res_id;
  logic                   busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit run_checks = 1'b0;

  always #5 clock = ~clock;

  vector_multiply_arbiter #(
    .MUL_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .VLEN(VLEN), .EXEC_W(EXEC_W)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_execution_vector(req_execution_vector),
    .req_vs2(req_vs2), .req_vs1(req_vs1),
    .mul_execution_vector(mul_execution_vector),
    .mul_vs2(mul_vs2), .mul_vs1(mul_vs1), .mul_vd(mul_vd),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_vd(res_vd), .res_id(res_id), .busy(busy)
  );

  function automatic logic [VLEN-1:0] vmul(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    r = '0;
    for (int e = 0; e < NEL; e++) r[e*SEW +: SEW] = SEW'(a[e*SEW +: SEW] * b[e*SEW +: SEW]);
    return r;
  endfunction

  // Stand-in for the multiply datapath: two-edge latency from mul_* to mul_vd.
  logic [VLEN-1:0] dp1, dp2;
  always @(posedge clock) begin
    dp1 <= vmul(mul_vs2, mul_vs1);
    dp2 <= dp1;
  end
  assign mul_vd = dp2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: ops granted but not yet popped, each with the cycle it becomes visible.
  logic [VLEN:0] exp_q[$];
  int            rdy_q[$];
  logic          pop_ids[$];
  int            cyc = 0;
  int            outstanding = 0;
  int            n_grants = 0;
  logic          prio = 1'b0;
  logic [1:0]    exp_ready;
  logic          exp_res_valid;

  task automatic model_outputs();
    exp_ready = 2'b00;
    if (!reset && outstanding < DEPTH) begin
      if (req_valid == 2'b11) exp_ready[prio] = 1'b1;
      else exp_ready = req_valid;
    end
    exp_res_valid = !reset && exp_q.size() > 0 && rdy_q[0] <= cyc;
  endtask

  always @(posedge clock) begin
    logic g, did_pop, did_grant;
    if (reset) begin
      exp_q.delete();
      rdy_q.delete();
      outstanding = 0;
      prio = 1'b0;
    end else begin
      model_outputs();
      did_pop   = exp_res_valid && res_ready;
      did_grant = (exp_ready != 2'b00);
      if (did_pop) begin
        pop_ids.push_back(exp_q[0][VLEN]);
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (did_grant) begin
        g = exp_ready[1];
        exp_q.push_back({g, vmul(req_vs2[g], req_vs1[g])});
        rdy_q.push_back(cyc + LAT + 1);
        prio = ~g;
        n_grants++;
      end
      outstanding = outstanding + int'(did_grant) - int'(did_pop);
    end
    cyc++;
  end

  always @(negedge clock) begin
    logic g;
    if (run_checks) begin
      model_outputs();
      g = exp_ready[1];
      check("req_ready", req_ready, exp_ready);
      check("res_valid", res_valid, exp_res_valid);
      if (exp_res_valid) begin
        check("res_id", res_id, exp_q[0][VLEN]);
        check("res_vd", res_vd, exp_q[0][VLEN-1:0]);
      end
      check("busy", busy, !reset && outstanding != 0);
      check("mul_vs2", mul_vs2, (exp_ready != 2'b00) ? req_vs2[g] : '0);
      check("mul_vs1", mul_vs1, (exp_ready != 2'b00) ? req_vs1[g] : '0);
      check("mul_ev", mul_execution_vector,
            (exp_ready != 2'b00) ? req_execution_vector[g] : '0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (outstanding != 0 && k < max_cyc) begin
      tick();
      k++;
    end
    check("drain_done", outstanding == 0, 1'b1);
    @(negedge clock);
    check("idle_busy", busy, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants, base;
    logic [1:0] pats [4];
    pats = '{2'b11, 2'b01, 2'b10, 2'b11};

    reset = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b1;
    req_execution_vector = {8'h44, 8'h33};
    req_vs2 = {32'h11111111, 32'h22222222};
    req_vs1 = {32'h33333333, 32'h44444444};
    run_checks = 1'b1;
    #2 reset = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_vs2", mul_vs2, 32'h0);
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    tick();

    // Test 1: single vmul from requester 0
    req_valid = 2'b01;
    req_execution_vector[0] = 8'h25;
    req_vs2[0] = 32'h03030303;
    req_vs1[0] = 32'h05050505;
    @(negedge clock);
    check("t1_ready", req_ready, 2'b01);
    check("t1_mul_vs2", mul_vs2, 32'h03030303);
    check("t1_mul_ev", mul_execution_vector, 8'h25);
    tick();
    req_valid = 2'b00;
    @(negedge clock);
    check("t1_c1_valid", res_valid, 1'b0);
    tick();
    @(negedge clock);
    check("t1_c2_valid", res_valid, 1'b0);
    tick();
    @(negedge clock);
    check("t1_c3_valid", res_valid, 1'b1);
    check("t1_c3_id", res_id, 1'b0);
    check("t1_c3_vd", res_vd, 32'h0F0F0F0F);
    tick();
    @(negedge clock);
    check("t1_c4_busy", busy, 1'b0);
    tick();

    // Test 2: both valid for 6 cycles, alternating grants
    do_reset();
    pop_ids.delete();
    req_vs2 = {32'hFF020710, 32'h01020304};
    req_vs1 = {32'h02030905, 32'h10203040};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("t2_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00;
    drain(20);
    check("t2_npops", pop_ids.size(), 6);
    for (int k = 0; k < 6 && k < pop_ids.size(); k++) check("t2_pop_id", pop_ids[k], k % 2);

    // Test 3: consumer stalled, credits run out after four grants
    res_ready = 1'b0;
    req_valid = 2'b11;
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (req_ready != 2'b00) grants++;
      tick();
    end
    check("t3_grants", grants, 4);
    res_ready = 1'b1;
    @(negedge clock);
    check("t3_pop_cycle_ready", req_ready, 2'b00);
    tick();
    res_ready = 1'b0;
    @(negedge clock);
    check("t3_regrant", |req_ready, 1'b1);
    tick();
    @(negedge clock);
    check("t3_full_again", req_ready, 2'b00);
    tick();
    res_ready = 1'b1;
    req_valid = 2'b00;
    drain(30);

    // Test 4: reset with two grants in flight
    req_valid = 2'b11;
    tick();
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clock);
    check("t4_rst_valid", res_valid, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("t4_no_res", res_valid, 1'b0);
      check("t4_no_busy", busy, 1'b0);
      tick();
    end

    // Test 5: res_ready toggling while grants continue
    base = n_grants;
    pop_ids.delete();
    for (int k = 0; k < 12; k++) begin
      res_ready = (k % 2 == 0);
      req_valid = pats[k % 4];
      req_execution_vector = {8'(k + 100), 8'(k)};
      req_vs2[0] = {4{8'(k + 1)}};
      req_vs1[0] = {4{8'(k + 3)}};
      req_vs2[1] = {4{8'(2 * k + 1)}};
      req_vs1[1] = {4{8'h07}};
      tick();
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    drain(40);
    check("t5_no_loss", pop_ids.size(), n_grants - base);
    check("t5_wrapped", (n_grants - base) > DEPTH, 1'b1);

    run_checks = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
